// File: rtl/adc_signal_conditioner.sv
// -----------------------------------------------------------------------------
// adc_signal_conditioner
//   Turns the raw accel-pedal (CH0) and CdS light (CH1) bytes coming from the
//   SPI ADC controller into clean values for the speed model and the headlight
//   logic. Both channels are sampled once per SAMPLE_DIV clocks and
//   boxcar-averaged over 2^AVG_LOG2 samples. The accel average has a deadband
//   at the bottom, and the CdS average drives a hysteretic "dark" flag.
//
// Ports
//   clk           in   1  system clock
//   rst           in   1  asynchronous, active-high reset
//   adc_accel     in   8  raw accel byte (only the tick-cycle value is used)
//   adc_cds       in   8  raw CdS byte (only the tick-cycle value is used)
//   accel_level   out  8  averaged accel after deadband
//   cds_level     out  8  averaged CdS value
//   dark          out  1  headlight request with hysteresis
//   sample_valid  out  1  one-cycle pulse when the outputs update
// -----------------------------------------------------------------------------
module adc_signal_conditioner #(
    parameter int SAMPLE_DIV     = 50000,
    parameter int AVG_LOG2       = 3,
    parameter int ACCEL_DEADBAND = 8,
    parameter int CDS_DARK_ON    = 60,
    parameter int CDS_DARK_OFF   = 80
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] adc_accel,
    input  logic [7:0] adc_cds,
    output logic [7:0] accel_level,
    output logic [7:0] cds_level,
    output logic       dark,
    output logic       sample_valid
);

    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int SUM_W = 8 + AVG_LOG2;
    localparam int CNT_W = $clog2(SAMPLE_DIV);

    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(SAMPLE_DIV - 1);
    localparam logic [7:0]       DEADBAND    = 8'(ACCEL_DEADBAND);
    localparam logic [7:0]       DARK_ON_TH  = 8'(CDS_DARK_ON);
    localparam logic [7:0]       DARK_OFF_TH = 8'(CDS_DARK_OFF);

    typedef enum logic [1:0] {
        S_WAIT   = 2'd0,
        S_UPDATE = 2'd1,
        S_OUTPUT = 2'd2
    } state_t;

    // ---------------------------------------------------------------- tick
    logic [CNT_W-1:0] tick_cnt_q;
    logic [CNT_W-1:0] tick_cnt_d;
    logic             tick;

    assign tick       = (tick_cnt_q == CNT_LAST);
    assign tick_cnt_d = tick ? '0 : tick_cnt_q + CNT_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
        end
    end

    // ----------------------------------------------------------------- FSM
    state_t state_q;
    state_t state_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_WAIT:   if (tick) state_d = S_UPDATE;
            S_UPDATE: state_d = S_OUTPUT;
            S_OUTPUT: state_d = S_WAIT;
            default:  state_d = S_WAIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_WAIT;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------- capture and pointer
    // Channel 0 is accel, channel 1 is CdS.
    logic [1:0][7:0]      hold_q;
    logic [AVG_LOG2-1:0]  wr_ptr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q   <= '0;
            wr_ptr_q <= '0;
        end else begin
            if (state_q == S_WAIT && tick) begin
                hold_q <= {adc_cds, adc_accel};
            end
            // Depth is a power of two, so the natural wrap of the pointer
            // returns it from DEPTH-1 to 0.
            if (state_q == S_UPDATE) begin
                wr_ptr_q <= wr_ptr_q + AVG_LOG2'(1);
            end
        end
    end

    // ------------------------------------------- per-channel running sums
    logic [7:0] avg [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
        logic [7:0]       ring_q [DEPTH];
        logic [SUM_W-1:0] sum_q;
        logic [SUM_W-1:0] sum_d;

        // Drop the oldest sample and add the newest in a single full-width
        // expression; the true result always fits, so modular wrap of the
        // intermediate terms is harmless.
        assign sum_d = sum_q + SUM_W'(hold_q[gi]) - SUM_W'(ring_q[wr_ptr_q]);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sum_q <= '0;
                for (int i = 0; i < DEPTH; i++) begin
                    ring_q[i] <= '0;
                end
            end else if (state_q == S_UPDATE) begin
                sum_q           <= sum_d;
                ring_q[wr_ptr_q] <= hold_q[gi];
            end
        end

        // Upper 8 bits of the sum are the truncated average.
        assign avg[gi] = sum_q[SUM_W-1 -: 8];
    end

    // ------------------------------------------------------------- outputs
    logic [7:0] accel_level_q;
    logic [7:0] cds_level_q;
    logic       dark_q;
    logic       sample_valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            accel_level_q  <= '0;
            cds_level_q    <= '0;
            dark_q         <= 1'b0;
            sample_valid_q <= 1'b0;
        end else begin
            sample_valid_q <= (state_q == S_OUTPUT);
            if (state_q == S_OUTPUT) begin
                cds_level_q   <= avg[1];
                accel_level_q <= (avg[0] <= DEADBAND) ? 8'd0 : avg[0];
                // Between the two thresholds the previous decision is kept.
                if (avg[1] < DARK_ON_TH) begin
                    dark_q <= 1'b1;
                end else if (avg[1] > DARK_OFF_TH) begin
                    dark_q <= 1'b0;
                end
            end
        end
    end

    assign accel_level  = accel_level_q;
    assign cds_level    = cds_level_q;
    assign dark         = dark_q;
    assign sample_valid = sample_valid_q;

endmodule

// File: tb/tb_adc_signal_conditioner.sv
// -----------------------------------------------------------------------------
// tb_adc_signal_conditioner
//   Directed scoreboard bench for adc_signal_conditioner with SAMPLE_DIV=4.
//   Each apply() call holds one input pair for one full sample period (so
//   exactly one tick captures it) and queues the hand-computed outputs; the
//   monitor pops one entry per sample_valid pulse and also checks pulse timing.
// -----------------------------------------------------------------------------
module tb_adc_signal_conditioner;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] adc_accel = 8'd0;
    logic [7:0] adc_cds = 8'd0;
    logic [7:0] accel_level;
    logic [7:0] cds_level;
    logic       dark;
    logic       sample_valid;

    typedef struct packed {
        logic [7:0] acc;
        logic [7:0] cds;
        logic       dark;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;
    bit   toggle_mode = 1'b0;
    int   cyc = 0;
    int   last_sv = -1;

    adc_signal_conditioner #(
        .SAMPLE_DIV(4),
        .AVG_LOG2  (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .adc_accel   (adc_accel),
        .adc_cds     (adc_cds),
        .accel_level (accel_level),
        .cds_level   (cds_level),
        .dark        (dark),
        .sample_valid(sample_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    always @(posedge clk) begin
        if (rst) begin
            cyc     = 0;
            last_sv = -1;
        end else begin
            cyc++;
        end
        #1;
        if (!rst && sample_valid) begin
            if (last_sv < 0) check("first_valid_cycle", cyc, 6);
            else             check("valid_spacing", cyc - last_sv, 4);
            last_sv = cyc;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid: got pulse at cycle %0d, want none", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("accel_level", int'(accel_level), int'(mon_e.acc));
                check("cds_level", int'(cds_level), int'(mon_e.cds));
                check("dark", int'(dark), int'(mon_e.dark));
                $display("sample cyc=%0d accel=%0d cds=%0d dark=%0d", cyc, accel_level, cds_level, dark);
            end
        end
    end

    // Holds one input pair for a whole sample period; in toggle mode the
    // first and third cycles carry inverted junk that must not be sampled.
    task automatic apply(input int acc, input int cds, input int ea, input int ec, input int ed);
        exp_t e_new;
        e_new.acc  = 8'(ea);
        e_new.cds  = 8'(ec);
        e_new.dark = 1'(ed);
        exp_q.push_back(e_new);
        for (int p = 0; p < 4; p++) begin
            if (toggle_mode && (p % 2 == 0)) begin
                adc_accel = ~8'(acc);
                adc_cds   = ~8'(cds);
            end else begin
                adc_accel = 8'(acc);
                adc_cds   = 8'(cds);
            end
            @(negedge clk);
        end
    endtask

    // Lets the last queued output appear, then resets mid-period and
    // releases on a falling edge so sample windows align with ticks.
    task automatic do_reset();
        repeat (3) @(negedge clk);
        check("pending_at_drain", exp_q.size(), 0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_accel_level", int'(accel_level), 0);
        check("rst_cds_level", int'(cds_level), 0);
        check("rst_dark", int'(dark), 0);
        check("rst_sample_valid", int'(sample_valid), 0);
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Accel ramp to 200 and CdS warm-up crossing the dark thresholds.
        do_reset();
        apply(200, 100,  25,  12, 1); apply(200, 100,  50,  25, 1); apply(200, 100,  75,  37, 1); apply(200, 100, 100,  50, 1);
        apply(200, 100, 125,  62, 1); apply(200, 100, 150,  75, 1); apply(200, 100, 175,  87, 0); apply(200, 100, 200, 100, 0);
        apply(200, 100, 200, 100, 0); apply(200, 100, 200, 100, 0);

        // Small accel stays in deadband, then 255 ramps to exactly 255.
        do_reset();
        apply(5, 255, 0,  31, 1); apply(5, 255, 0,  63, 1); apply(5, 255, 0,  95, 0); apply(5, 255, 0, 127, 0);
        apply(5, 255, 0, 159, 0); apply(5, 255, 0, 191, 0); apply(5, 255, 0, 223, 0); apply(5, 255, 0, 255, 0);
        for (int i = 0; i < 8; i++) apply(5, 255, 0, 255, 0);
        apply(255, 255,  36, 255, 0); apply(255, 255,  67, 255, 0); apply(255, 255,  98, 255, 0); apply(255, 255, 130, 255, 0);
        apply(255, 255, 161, 255, 0); apply(255, 255, 192, 255, 0); apply(255, 255, 223, 255, 0); apply(255, 255, 255, 255, 0);

        // CdS hysteresis: 100 -> 50 -> 70 -> 90, including avg == 60 and 80.
        do_reset();
        apply(0, 100, 0,  12, 1); apply(0, 100, 0,  25, 1); apply(0, 100, 0,  37, 1); apply(0, 100, 0,  50, 1);
        apply(0, 100, 0,  62, 1); apply(0, 100, 0,  75, 1); apply(0, 100, 0,  87, 0); apply(0, 100, 0, 100, 0);
        apply(0,  50, 0,  93, 0); apply(0,  50, 0,  87, 0); apply(0,  50, 0,  81, 0); apply(0,  50, 0,  75, 0);
        apply(0,  50, 0,  68, 0); apply(0,  50, 0,  62, 0); apply(0,  50, 0,  56, 1); apply(0,  50, 0,  50, 1);
        apply(0,  70, 0,  52, 1); apply(0,  70, 0,  55, 1); apply(0,  70, 0,  57, 1); apply(0,  70, 0,  60, 1);
        apply(0,  70, 0,  62, 1); apply(0,  70, 0,  65, 1); apply(0,  70, 0,  67, 1); apply(0,  70, 0,  70, 1);
        for (int i = 0; i < 8; i++) apply(0, 70, 0, 70, 1);
        apply(0,  90, 0,  72, 1); apply(0,  90, 0,  75, 1); apply(0,  90, 0,  77, 1); apply(0,  90, 0,  80, 1);
        apply(0,  90, 0,  82, 0); apply(0,  90, 0,  85, 0); apply(0,  90, 0,  87, 0); apply(0,  90, 0,  90, 0);

        // Inputs toggle every cycle; pointer wraps after 9 x 255, then 8 x 0.
        do_reset();
        toggle_mode = 1'b1;
        apply(255, 200,  31,  25, 1); apply(255, 200,  63,  50, 1); apply(255, 200,  95,  75, 1); apply(255, 200, 127, 100, 0);
        apply(255, 200, 159, 125, 0); apply(255, 200, 191, 150, 0); apply(255, 200, 223, 175, 0); apply(255, 200, 255, 200, 0);
        apply(255, 200, 255, 200, 0);
        apply(0, 200, 223, 200, 0); apply(0, 200, 191, 200, 0); apply(0, 200, 159, 200, 0); apply(0, 200, 127, 200, 0);
        apply(0, 200,  95, 200, 0); apply(0, 200,  63, 200, 0); apply(0, 200,  31, 200, 0); apply(0, 200,   0, 200, 0);
        toggle_mode = 1'b0;

        // Deadband edge: average of exactly 8 reads 0, average of 9 reads 9.
        do_reset();
        for (int i = 0; i < 8; i++) apply(8, 0, 0, 0, 1);
        apply(16, 0, 9, 0, 1);

        repeat (3) @(negedge clk);
        check("pending_at_end", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
